// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between an instruction-fetch port and a data port.
// Define MEM_PORT_ARBITER_FAIRNESS_EN to stop data traffic from starving fetch indefinitely.
module mem_port_arbiter #(
  parameter int unsigned LAT      = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_ack,
  output logic [63:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Counter value in the WAIT cycle where mem_rdata is valid.
  localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

  if (LAT < 1 || LAT > 15) begin : g_lat_range
    $error("mem_port_arbiter: LAT must be in 1..15");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
  end

  state_e      state_q,    state_d;
  logic        grant_dm_q, grant_dm_d;
  logic        wr_q,       wr_d;
  logic [63:0] addr_q,     addr_d;
  logic [63:0] wdata_q,    wdata_d;
  logic [63:0] rdata_q,    rdata_d;
  logic [3:0]  lat_cnt_q,  lat_cnt_d;
  logic        pick_dm;
  logic        grant;

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_WAIT);

  logic [3:0] starve_q, starve_d;

  // Once fetch has been passed over STARVE_LIMIT times, it takes the next slot.
  always_comb begin
    pick_dm = dm_req;
    if (if_req && (starve_q >= STARVE_LIMIT)) pick_dm = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (!pick_dm)   starve_d = '0;
      else if (if_req) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign pick_dm = dm_req;
`endif

  assign grant = (state_q == IDLE) && (if_req || dm_req);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_dm_d = grant_dm_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    lat_cnt_d  = lat_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          grant_dm_d = pick_dm;
          wr_d       = pick_dm & dm_wr;
          addr_d     = pick_dm ? dm_addr : if_addr;
          wdata_d    = pick_dm ? dm_wdata : '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched request and captured data are reset as well, so every output is 0 while RST is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      grant_dm_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_dm_q <= grant_dm_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) & ~grant_dm_q;
  assign dm_ack    = (state_q == RESP) &  grant_dm_q;
  assign if_rdata  = rdata_q[31:0];
  assign dm_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the arbitration and timing rules.
module tb_mem_port_arbiter;

  localparam int LAT      = 1;
  localparam int MAX_WAIT = 4;
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_wr;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [63:0] mem_dut [logic [63:0]];
  logic [63:0] mem_ref [logic [63:0]];

  mem_port_arbiter #(.LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h3C5A_96E1};
  endfunction

  function automatic logic [63:0] dut_mem_read(input logic [63:0] a);
    return mem_dut.exists(a) ? mem_dut[a] : dflt(a);
  endfunction

  function automatic logic [63:0] ref_mem_read(input logic [63:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
  endfunction

  function automatic logic [63:0] rand_addr();
    return 64'h1000 + (64'($urandom_range(0, 7)) << 3);
  endfunction

  // Memory: read data appears LAT cycles after the mem_en cycle, random junk otherwise.
  initial begin : responder
    int          rd_cnt;
    logic [63:0] rd_val;
    rd_cnt    = 0;
    rd_val    = '0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      mem_rdata = {$urandom, $urandom};
      if (!RST) begin
        rd_cnt = 0;
      end else if (mem_en) begin
        if (mem_wr) mem_dut[mem_addr] = mem_wdata;
        else begin
          rd_val = dut_mem_read(mem_addr);
          rd_cnt = LAT;
        end
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) mem_rdata = rd_val;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int act_seen;
    @(negedge CLK);
    total++; if (busy !== 1'b0)      $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (mem_en !== 1'b0)    $display("FAIL reset_mem_en got=%b exp=0", mem_en); else passed++;
    total++; if (mem_wr !== 1'b0)    $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); else passed++;
    total++; if (if_ack !== 1'b0)    $display("FAIL reset_if_ack got=%b exp=0", if_ack); else passed++;
    total++; if (dm_ack !== 1'b0)    $display("FAIL reset_dm_ack got=%b exp=0", dm_ack); else passed++;
    total++; if (if_rdata !== '0)    $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); else passed++;
    total++; if (dm_rdata !== '0)    $display("FAIL reset_dm_rdata got=%h exp=0", dm_rdata); else passed++;
    total++; if (mem_addr !== '0)    $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else passed++;
    total++; if (mem_wdata !== '0)   $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else passed++;
    RST = 1'b1;
    act_seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (busy || mem_en || if_ack || dm_ack) act_seen = 1;
    end
    total++; if (act_seen != 0) $display("FAIL reset_idle_activity got=%0d exp=0", act_seen); else passed++;
  endtask

  task automatic test_fetch_basic();
    int          en_cyc, en_cnt, ack_cyc, ack_cnt, dm_seen, wr_seen;
    logic [63:0] en_addr;
    logic [31:0] got;
    do_reset();
    mem_dut[64'h40] = 64'h0000_0000_00A0_0093;
    if_addr = 64'h40;
    if_req  = 1'b1;
    en_cyc = -1; en_cnt = 0; ack_cyc = -1; ack_cnt = 0; dm_seen = 0; wr_seen = 0;
    en_addr = '0; got = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (mem_en) begin
        en_cnt++;
        if (mem_wr) wr_seen = 1;
        if (en_cyc < 0) begin en_cyc = c; en_addr = mem_addr; end
      end
      if (dm_ack) dm_seen = 1;
      if (if_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = c; got = if_rdata; end
        if_req = 1'b0;
      end
    end
    total++; if (en_cyc != 1)           $display("FAIL fetch_en_cycle got=%0d exp=1", en_cyc); else passed++;
    total++; if (en_cnt != 1)           $display("FAIL fetch_en_count got=%0d exp=1", en_cnt); else passed++;
    total++; if (wr_seen != 0)          $display("FAIL fetch_mem_wr got=%0d exp=0", wr_seen); else passed++;
    total++; if (en_addr !== 64'h40)    $display("FAIL fetch_mem_addr got=%h exp=40", en_addr); else passed++;
    total++; if (ack_cyc != LAT + 2)    $display("FAIL fetch_ack_cycle got=%0d exp=%0d", ack_cyc, LAT + 2); else passed++;
    total++; if (ack_cnt != 1)          $display("FAIL fetch_ack_count got=%0d exp=1", ack_cnt); else passed++;
    total++; if (got !== 32'h00A00093)  $display("FAIL fetch_rdata got=%h exp=00a00093", got); else passed++;
    total++; if (dm_seen != 0)          $display("FAIL fetch_dm_ack got=%0d exp=0", dm_seen); else passed++;
  endtask

  task automatic test_data_write();
    int          en_cnt, en_wr, ack_cyc, if_seen, rd_cyc;
    logic [63:0] en_addr, en_wdata, rd_got;
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 64'h100; dm_wdata = 64'hDEADBEEF_CAFEF00D;
    en_cnt = 0; en_wr = 0; ack_cyc = -1; if_seen = 0; en_addr = '0; en_wdata = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (mem_en) begin en_cnt++; en_wr = int'(mem_wr); en_addr = mem_addr; en_wdata = mem_wdata; end
      if (if_ack) if_seen = 1;
      if (dm_ack) begin
        if (ack_cyc < 0) ack_cyc = c;
        dm_req = 1'b0;
      end
    end
    total++; if (en_cnt != 1)                   $display("FAIL wr_en_count got=%0d exp=1", en_cnt); else passed++;
    total++; if (en_wr != 1)                    $display("FAIL wr_mem_wr got=%0d exp=1", en_wr); else passed++;
    total++; if (en_addr !== 64'h100)           $display("FAIL wr_mem_addr got=%h exp=100", en_addr); else passed++;
    total++; if (en_wdata !== 64'hDEADBEEF_CAFEF00D) $display("FAIL wr_mem_wdata got=%h exp=deadbeefcafef00d", en_wdata); else passed++;
    total++; if (ack_cyc != LAT + 2)            $display("FAIL wr_ack_cycle got=%0d exp=%0d", ack_cyc, LAT + 2); else passed++;
    total++; if (if_seen != 0)                  $display("FAIL wr_if_ack got=%0d exp=0", if_seen); else passed++;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 64'h100; dm_wdata = '0;
    rd_cyc = -1; rd_got = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (dm_ack) begin
        if (rd_cyc < 0) begin rd_cyc = c; rd_got = dm_rdata; end
        dm_req = 1'b0;
      end
    end
    total++; if (rd_cyc != LAT + 2)                 $display("FAIL rd_ack_cycle got=%0d exp=%0d", rd_cyc, LAT + 2); else passed++;
    total++; if (rd_got !== 64'hDEADBEEF_CAFEF00D)  $display("FAIL rd_back got=%h exp=deadbeefcafef00d", rd_got); else passed++;
  endtask

  task automatic test_simultaneous();
    int          dm_cyc, if_cyc, both;
    logic [63:0] dm_got, exp64;
    logic [31:0] if_got, exp32;
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 64'h180;
    if_req = 1'b1; if_addr = 64'h80;
    dm_cyc = -1; if_cyc = -1; both = 0; dm_got = '0; if_got = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (if_ack && dm_ack) both = 1;
      if (dm_ack) begin if (dm_cyc < 0) begin dm_cyc = c; dm_got = dm_rdata; end dm_req = 1'b0; end
      if (if_ack) begin if (if_cyc < 0) begin if_cyc = c; if_got = if_rdata; end if_req = 1'b0; end
    end
    exp64 = dflt(64'h180);
    exp32 = dflt(64'h80) >> 0;
    total++; if (dm_cyc != LAT + 2)          $display("FAIL sim_dm_ack_cycle got=%0d exp=%0d", dm_cyc, LAT + 2); else passed++;
    total++; if (if_cyc - dm_cyc != LAT + 3) $display("FAIL sim_fetch_gap got=%0d exp=%0d", if_cyc - dm_cyc, LAT + 3); else passed++;
    total++; if (both != 0)                  $display("FAIL sim_both_acks got=%0d exp=0", both); else passed++;
    total++; if (dm_got !== exp64)           $display("FAIL sim_dm_rdata got=%h exp=%h", dm_got, exp64); else passed++;
    total++; if (if_got !== exp32)           $display("FAIL sim_if_rdata got=%h exp=%h", if_got, exp32); else passed++;
  endtask

  task automatic test_fairness();
    int seq [10];
    int n, both, exp_dm;
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 64'h1A0;
    if_req = 1'b1; if_addr = 64'hA0;
    n = 0; both = 0;
    for (int c = 1; c <= 10 * (LAT + 3) + 10 && n < 10; c++) begin
      @(negedge CLK);
      if (if_ack && dm_ack) both = 1;
      if (dm_ack)      begin seq[n] = 1; n++; end
      else if (if_ack) begin seq[n] = 0; n++; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    total++; if (n != 10)   $display("FAIL fair_grant_count got=%0d exp=10", n); else passed++;
    total++; if (both != 0) $display("FAIL fair_both_acks got=%0d exp=0", both); else passed++;
    for (int i = 0; i < n; i++) begin
      exp_dm = (FAIR && (i % (MAX_WAIT + 1)) == MAX_WAIT) ? 0 : 1;
      total++; if (seq[i] != exp_dm) $display("FAIL fair_grant_%0d got_dm=%0d exp_dm=%0d", i, seq[i], exp_dm); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int          act_seen, ack_cyc;
    logic [31:0] got, exp32;
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 64'h200;
    @(negedge CLK);
    @(negedge CLK);
    total++; if (busy !== 1'b1) $display("FAIL rmid_inflight_busy got=%b exp=1", busy); else passed++;
    RST = 1'b0;
    dm_req = 1'b0;
    #1;
    total++; if (busy !== 1'b0)     $display("FAIL rmid_busy got=%b exp=0", busy); else passed++;
    total++; if (mem_en !== 1'b0)   $display("FAIL rmid_mem_en got=%b exp=0", mem_en); else passed++;
    total++; if (dm_ack !== 1'b0)   $display("FAIL rmid_dm_ack got=%b exp=0", dm_ack); else passed++;
    total++; if (mem_addr !== '0)   $display("FAIL rmid_mem_addr got=%h exp=0", mem_addr); else passed++;
    act_seen = 0;
    repeat (2) begin @(negedge CLK); if (if_ack || dm_ack || mem_en || busy) act_seen = 1; end
    RST = 1'b1;
    repeat (4) begin @(negedge CLK); if (if_ack || dm_ack || mem_en || busy) act_seen = 1; end
    total++; if (act_seen != 0) $display("FAIL rmid_dropped_txn got=%0d exp=0", act_seen); else passed++;
    if_req = 1'b1; if_addr = 64'h2C0;
    ack_cyc = -1; got = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (if_ack) begin if (ack_cyc < 0) begin ack_cyc = c; got = if_rdata; end if_req = 1'b0; end
    end
    exp32 = dflt(64'h2C0) >> 0;
    total++; if (ack_cyc != LAT + 2) $display("FAIL rmid_next_ack_cycle got=%0d exp=%0d", ack_cyc, LAT + 2); else passed++;
    total++; if (got !== exp32)      $display("FAIL rmid_next_rdata got=%h exp=%h", got, exp32); else passed++;
  endtask

  // Transaction-level model: a grant at cycle s gives mem_en at s+1, ack at s+LAT+2, idle at s+LAT+3.
  task automatic test_random();
    bit          act, l_dm, l_wr, e_busy, e_en, e_ifack, e_dmack;
    int          st, ack_at, starve;
    logic [63:0] l_addr, l_wd, exp_rd;
    do_reset();
    act = 0; l_dm = 0; l_wr = 0; st = 0; starve = 0; l_addr = '0; l_wd = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      ack_at  = st + LAT + 2;
      e_busy  = act && (k > st);
      e_en    = act && (k == st + 1);
      e_ifack = act && (k == ack_at) && !l_dm;
      e_dmack = act && (k == ack_at) && l_dm;
      total++; if (busy !== e_busy)          $display("FAIL rnd_busy k=%0d got=%b exp=%b", k, busy, e_busy); else passed++;
      total++; if (mem_en !== e_en)          $display("FAIL rnd_mem_en k=%0d got=%b exp=%b", k, mem_en, e_en); else passed++;
      total++; if (mem_wr !== (e_en && l_wr)) $display("FAIL rnd_mem_wr k=%0d got=%b exp=%b", k, mem_wr, e_en && l_wr); else passed++;
      total++; if (if_ack !== e_ifack)       $display("FAIL rnd_if_ack k=%0d got=%b exp=%b", k, if_ack, e_ifack); else passed++;
      total++; if (dm_ack !== e_dmack)       $display("FAIL rnd_dm_ack k=%0d got=%b exp=%b", k, dm_ack, e_dmack); else passed++;
      if (e_en) begin
        total++; if (mem_addr !== l_addr) $display("FAIL rnd_mem_addr k=%0d got=%h exp=%h", k, mem_addr, l_addr); else passed++;
        if (l_wr) begin
          total++; if (mem_wdata !== l_wd) $display("FAIL rnd_mem_wdata k=%0d got=%h exp=%h", k, mem_wdata, l_wd); else passed++;
          mem_ref[l_addr] = l_wd;
        end
      end
      if (e_ifack) begin
        exp_rd = ref_mem_read(l_addr);
        total++; if (if_rdata !== exp_rd[31:0]) $display("FAIL rnd_if_rdata k=%0d got=%h exp=%h", k, if_rdata, exp_rd[31:0]); else passed++;
      end
      if (e_dmack && !l_wr) begin
        exp_rd = ref_mem_read(l_addr);
        total++; if (dm_rdata !== exp_rd) $display("FAIL rnd_dm_rdata k=%0d got=%h exp=%h", k, dm_rdata, exp_rd); else passed++;
      end

      // Requesters: the served one drops on ack, and scrambles its fields while in flight.
      if (act && k == ack_at) begin
        if (l_dm) dm_req = 1'b0; else if_req = 1'b0;
      end else if (act && k > st) begin
        if (l_dm) begin
          dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom}; dm_wr = 1'($urandom_range(0, 1));
        end else begin
          if_addr = {$urandom, $urandom};
        end
      end
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_addr = rand_addr(); dm_wr = 1'($urandom_range(0, 1)); dm_wdata = {$urandom, $urandom};
      end

      if (!act && (if_req || dm_req)) begin
        l_dm = dm_req && !(FAIR && if_req && starve >= MAX_WAIT);
        if (!l_dm)       starve = 0;
        else if (if_req) starve++;
        l_wr   = l_dm && dm_wr;
        l_addr = l_dm ? dm_addr : if_addr;
        l_wd   = dm_wdata;
        st     = k;
        act    = 1;
      end else if (act && k == ack_at) begin
        act = 0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    #2 RST = 1'b0;
    test_reset();
    test_fetch_basic();
    test_data_write();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory read latency in cycles (legal 1..15).
REQ-002 Parameter MAX_WAIT, default 4, consecutive data grants tolerated while fetch waits (legal 1..15).
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held until if_ack.
REQ-006 if_addr  input  64  fetch address (PC).
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched word; valid while if_ack=1.
REQ-009 dm_req  input  1  data request; held until dm_ack.
REQ-010 dm_wr  input  1  1=write, 0=read.
REQ-011 dm_addr  input  64  data address.
REQ-012 dm_wdata  input  64  write data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  64  read data; valid while dm_ack=1 and dm_wr=0.
REQ-015 mem_en  output  1  memory access strobe, exactly one cycle per transaction.
REQ-016 mem_wr  output  1  memory write enable; only with mem_en=1.
REQ-017 mem_addr  output  64  memory address.
REQ-018 mem_wdata  output  64  memory write data.
REQ-019 mem_rdata  input  64  memory read data, valid LAT cycles after the mem_en cycle.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: no request -> stay; any request -> latch winner, address, wr, wdata; -> ISSUE.
REQ-023 Arbitration: dm_req wins over if_req unless the fairness override (REQ-034) is active.
REQ-024 ISSUE (1 cycle): mem_en=1, mem_addr/mem_wr/mem_wdata from latched values; mem_wr=0 always for fetch; -> WAIT.
REQ-025 WAIT: count LAT cycles; in the cycle mem_rdata becomes valid, capture it; -> RESP.
REQ-026 RESP (1 cycle): pulse winner's ack; if_rdata=captured[31:0], dm_rdata=captured[63:0]; -> IDLE.
REQ-027 Latency req-seen-in-IDLE to ack SHALL be LAT+2 cycles for reads and writes alike.
REQ-028 Requests arriving outside IDLE SHALL be ignored until IDLE; request inputs are sampled only in IDLE.
REQ-029 Minimum spacing between transactions SHALL be LAT+3 cycles (RESP always returns to IDLE).
REQ-030 Simultaneous if_req and dm_req in IDLE: exactly one granted; the other stays pending, not lost.
REQ-031 Latched fields SHALL be frozen from IDLE exit to RESP; input changes mid-transaction have no effect.
REQ-032 if_ack and dm_ack SHALL never be high in the same cycle.

Reset
REQ-033 RST=0 SHALL immediately force IDLE, all outputs 0, data registers 0, starvation counter 0; an in-flight transaction is dropped with no ack.

Configuration
REQ-034 Macro MEM_PORT_ARBITER_FAIRNESS_EN defined: starvation counter increments on each data grant made while if_req=1, clears on any fetch grant; at count=MAX_WAIT the next grant goes to fetch even if dm_req=1.
REQ-035 Macro undefined: strict data priority, no counter logic present; fetch may starve indefinitely.

Verification
REQ-036 LAT=1, if_req alone, if_addr=0x40, mem_rdata=0x00000000_00A00093 -> mem_en at cycle 1, if_ack at cycle 3, if_rdata=0x00A00093.
REQ-037 dm_req write, dm_addr=0x100, dm_wdata=0xDEADBEEF_CAFEF00D -> one mem_en cycle with mem_wr=1, matching addr/data; dm_ack at LAT+2; if_ack stays 0.
REQ-038 if_req and dm_req asserted same cycle -> data served first, fetch ack exactly LAT+3 cycles after dm_ack.
REQ-039 With FAIRNESS_EN, MAX_WAIT=4, dm_req and if_req held high continuously -> grant pattern D,D,D,D,F repeating; without macro -> only D.
REQ-040 RST pulsed low during WAIT -> busy=0, mem_en=0, no ack; next request after release completes normally in LAT+2.
